console_text_buffer: RTL and testbench
======================================

// Module: console_text_buffer
// PURPOSE
//  Character/attribute store that sits directly upstream of the console glyph renderer.
//  Writer side: accepts a byte stream through a valid/ready handshake and places printable
//  bytes at a hardware cursor. Handles CR, LF, BS and FF (clear), and scrolls the screen.
//  Display side: maps pixel coordinates cx/cy to the cell's character/attribute.
//  Output latency is fixed, so the renderer gets aligned data.
// PARAMETERS
//  COLS          80     text columns (glyph cell 8 px wide)
//  ROWS          25     text rows (glyph cell 16 px tall)
//  DEFAULT_ATTR  8'h0F  attribute written by clear/scroll fill
// PORTS
//  clk_pixel    in   1   pixel clock, sole clock
//  reset_n      in   1   asynchronous, active-low reset
//  cx           in   10  display pixel x
//  cy           in   10  display pixel y
//  character    out  8   cell character, READ_LATENCY=2 cycles after cx/cy
//  attribute    out  8   cell attribute, same timing as character
//  in_valid     in   1   writer byte valid
//  in_ready     out  1   block can accept a byte this cycle
//  in_char      in   8   byte (printable or control)
//  in_attr      in   8   attribute for printable bytes
//  cursor_col   out  7   current cursor column, 0..COLS-1
//  cursor_row   out  5   current logical cursor row, 0..ROWS-1
// BEHAVIOUR
//  Reset values:
//   - character=0, attribute=0, cursor 0/0, top_row=0, in_ready=0.
//   - The FSM enters CLEAR_ALL. RAM contents are not reset.
//  Transfer rule: a byte transfers when in_valid && in_ready.
//  in_ready=1 only in IDLE; in_char/in_attr are sampled on the transfer.
//  Control bytes:
//   - 0x0D: col=0.
//   - 0x0A: col=0, then row advance.
//   - 0x08: col-1 if col>0, else no change; no erase.
//   - 0x0C: go to CLEAR_ALL.
//  Other bytes 0x00-0x1F: ignored.
//  Printable bytes: write {in_attr,in_char} at (col,row), then col+1.
//   If col was COLS-1, set col=0 and do a row advance.
//  Row advance:
//   - row<ROWS-1: row+1.
//   - Otherwise: row stays, top_row=(top_row+1) mod ROWS, FSM goes to SCROLL_CLEAR.
//  FSM states:
//   - CLEAR_ALL: write {DEFAULT_ATTR,0x20} to cells 0..COLS*ROWS-1, one per cycle.
//     Then cursor=0/0, top_row=0, go to IDLE.
//   - SCROLL_CLEAR: fill the new bottom physical row (top_row+ROWS-1) mod ROWS the same way.
//     Takes COLS cycles, then IDLE.
//   - IDLE: in_ready=1.
//  Physical address: ((logical_row+top_row) mod ROWS)*COLS + col.
//   Mod is a compare/subtract, no divider; the multiply is by a constant.
//  Display read:
//   - Stage 1 registers col=cx[9:3] and lrow=cy[9:4], and computes the physical address.
//   - Stage 2 is the RAM read and output register.
//   - If cx>=COLS*8 or cy>=ROWS*16, force character=0, attribute=0 (range flag pipelined).
//  The read port is independent of the write port and is never stalled.
//  Same-cell read/write collision: old or new data is acceptable; no hazard stall.
//  Display reads use the top_row value registered with stage 1. A scroll mid-frame tears
//  for one frame; this is accepted.
//  Reset asserted mid-clear or mid-scroll: all state is discarded and CLEAR_ALL restarts
//  at cell 0.
//  Arithmetic: addresses are $clog2(COLS*ROWS) bits; counters saturate at their bound
//  and never wrap.
// STRUCTURE
//  console_pkg: CH_CR/CH_LF/CH_BS/CH_FF/CH_SPACE constants, GLYPH_W=8, GLYPH_H=16,
//   FSM state enum.
//  Sub-module console_text_ram: simple dual-port RAM, depth COLS*ROWS, 16-bit
//   {attr,char} words, 1-cycle registered read, synchronous write.
//  All other logic (FSM, cursor, address pipeline) stays in this module.
// TESTING
//  1. Reset released -> in_ready low exactly 2000 cycles.
//     Then every cell reads 0x20/0x0F, cursor 0/0.
//  2. Write 0x41 attr 0x1F -> cursor_col=1. cx=0..7, cy=0..15 give 0x41/0x1F two cycles later.
//  3. 80 printable bytes from col 0 -> cursor 0/1. Byte 80 appears at cx=0, cy=16.
//  4. Cursor row 24, send 0x0A:
//     - top_row=1 and in_ready low 80 cycles.
//     - Old row 1 content now appears at cy=0; cy=384..399 reads 0x20/0x0F.
//  5. 0x08 at col 0 -> cursor unchanged. 0x0C mid-line -> 2000-cycle clear, cursor 0/0.
//  6. cx=640 or cy=400 -> character=0x00, attribute=0x00.
//     Reset pulsed mid-scroll -> full CLEAR_ALL reruns.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants and FSM encoding for the console text buffer.
package console_pkg;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  typedef enum logic [1:0] {
    CLEAR_ALL    = 2'd0,
    SCROLL_CLEAR = 2'd1,
    IDLE         = 2'd2
  } state_t;
endpackage

// File: rtl/console_text_ram.sv
// Simple dual-port cell store: synchronous write, one-cycle registered read.
module console_text_ram #(
  parameter int DEPTH = 2000,
  parameter int AW    = 11,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, independent of the write port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/console_text_buffer.sv
// Console text buffer: byte-stream writer with cursor/scroll handling and a
// fixed two-cycle pixel-to-cell read path for the glyph renderer.
module console_text_buffer
  import console_pkg::*;
#(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 25,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [7:0] character,
  output logic [7:0] attribute,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic [7:0] in_attr,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_CCNT = AW'(COLS - 1);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
  localparam logic [15:0]   BLANK     = {DEFAULT_ATTR, CH_SPACE};

  // Logical row -> physical row; the sum is below 2*ROWS so one subtract wraps it.
  function automatic logic [4:0] wrap_row(input logic [4:0] lrow, input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, lrow} + {1'b0, top};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] row_base(input logic [4:0] prow);
    return AW'(prow) * AW'(COLS);
  endfunction

  state_t        state, state_n;
  logic [6:0]    col, col_n;
  logic [4:0]    row, row_n;
  logic [4:0]    top, top_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          adv;

  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;

  logic [6:0]    rd_col;
  logic [4:0]    rd_row;
  logic [4:0]    rd_top;
  logic          rd_ok;
  logic          out_ok;
  logic [AW-1:0] raddr;
  logic [15:0]   rdata;

  // Writer state: FSM, cursor, scroll origin and fill counter
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR_ALL;
      col   <= '0;
      row   <= '0;
      top   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      top   <= top_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, cursor movement and write-port control
  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    top_n    = top;
    cnt_n    = cnt;
    adv      = 1'b0;
    we       = 1'b0;
    waddr    = row_base(wrap_row(row, top)) + AW'(col);
    wdata    = {in_attr, in_char};
    in_ready = 1'b0;
    case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = BLANK;
        if (cnt == LAST_CELL) begin
          state_n = IDLE;
          cnt_n   = '0;
          col_n   = '0;
          row_n   = '0;
          top_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SCROLL_CLEAR: begin
        // top already advanced, so the bottom logical row is the recycled one
        we    = 1'b1;
        waddr = row_base(wrap_row(LAST_ROW, top)) + cnt;
        wdata = BLANK;
        if (cnt == LAST_CCNT) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_char)
            CH_CR: col_n = '0;
            CH_LF: begin
              col_n = '0;
              adv   = 1'b1;
            end
            CH_BS: if (col != '0) col_n = col - 1'b1;
            CH_FF: begin
              state_n = CLEAR_ALL;
              cnt_n   = '0;
            end
            default: begin
              if (in_char >= CH_SPACE) begin
                we = 1'b1;
                if (col == LAST_COL) begin
                  col_n = '0;
                  adv   = 1'b1;
                end else begin
                  col_n = col + 1'b1;
                end
              end
            end
          endcase
          if (adv) begin
            if (row < LAST_ROW) begin
              row_n = row + 1'b1;
            end else begin
              top_n   = (top == LAST_ROW) ? 5'd0 : top + 1'b1;
              state_n = SCROLL_CLEAR;
              cnt_n   = '0;
            end
          end
        end
      end
      default: state_n = CLEAR_ALL;
    endcase
  end

  // Display stage 1: latch cell coordinates, scroll origin and range flag
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rd_col <= '0;
      rd_row <= '0;
      rd_top <= '0;
      rd_ok  <= 1'b0;
      out_ok <= 1'b0;
    end else begin
      rd_col <= cx[9:3];
      rd_row <= cy[8:4];
      rd_top <= top;
      rd_ok  <= (cx < 10'(COLS * GLYPH_W)) && (cy < 10'(ROWS * GLYPH_H));
      out_ok <= rd_ok;
    end
  end

  // Out-of-range pixels read a harmless in-range address; their data is masked
  assign raddr = rd_ok ? row_base(wrap_row(rd_row, rd_top)) + AW'(rd_col) : '0;

  console_text_ram #(.DEPTH(CELLS), .AW(AW), .DW(16)) u_ram (
    .clk   (clk_pixel),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign character  = out_ok ? rdata[7:0]  : 8'h00;
  assign attribute  = out_ok ? rdata[15:8] : 8'h00;
  assign cursor_col = col;
  assign cursor_row = row;
endmodule

// File: tb/tb_console_text_buffer.sv
// Directed/randomized bench for console_text_buffer with a logical-screen model.
module tb_console_text_buffer;
  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;
  localparam logic [15:0] BLANK = 16'h0F20;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [9:0] cx, cy;
  logic [7:0] character, attribute;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char, in_attr;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int vectors = 0;
  int miscompares = 0;

  // Logical screen: row 0 is always the top line shown on the display
  logic [15:0] scr [ROWS][COLS];
  int mcol, mrow;
  int qx[$], qy[$];

  console_text_buffer dut (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .cx         (cx),
    .cy         (cy),
    .character  (character),
    .attribute  (attribute),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    mcol = 0;
    mrow = 0;
  endfunction

  function automatic int m_adv();
    if (mrow < ROWS - 1) begin
      mrow++;
      return 0;
    end
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
    return COLS;
  endfunction

  // Applies one byte to the model; returns expected busy cycles afterwards
  function automatic int m_byte(input logic [7:0] c, input logic [7:0] a);
    int busy = 0;
    case (c)
      8'h0D: mcol = 0;
      8'h0A: begin mcol = 0; busy = m_adv(); end
      8'h08: if (mcol > 0) mcol--;
      8'h0C: begin m_clear(); busy = CELLS; end
      default: if (c >= 8'h20) begin
        scr[mrow][mcol] = {a, c};
        if (mcol == COLS - 1) begin mcol = 0; busy = m_adv(); end
        else mcol++;
      end
    endcase
    return busy;
  endfunction

  function automatic logic [15:0] exp_at(input int x, input int y);
    if (x >= COLS * 8 || y >= ROWS * 16) return 16'h0000;
    return scr[y / 16][x / 8];
  endfunction

  // Streams queued coordinates one per cycle; output checked two cycles later
  task automatic run_reads(input string tag);
    logic [15:0] ex[$];
    logic [15:0] e;
    int n;
    n = qx.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk_pixel);
      if (i >= 2) begin
        e = ex.pop_front();
        check(tag, {attribute, character}, e);
      end
      if (i < n) begin
        cx = 10'(qx[i]);
        cy = 10'(qy[i]);
        ex.push_back(exp_at(qx[i], qy[i]));
      end
    end
    qx.delete();
    qy.delete();
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        qx.push_back(c * 8 + int'($urandom_range(0, 7)));
        qy.push_back(r * 16 + int'($urandom_range(0, 15)));
      end
    run_reads(tag);
  endtask

  task automatic transfer(input logic [7:0] c, input logic [7:0] a);
    int n = 0;
    @(negedge clk_pixel);
    while (!in_ready && n < 5000) begin
      @(negedge clk_pixel);
      n++;
    end
    check("ready_before_send", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    @(posedge clk_pixel);
    #1 in_valid = 1'b0;
  endtask

  task automatic count_busy(input string tag, input int exp);
    int n = 0;
    while (!in_ready && n < 5000) begin
      @(posedge clk_pixel);
      #1 n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int busy;
    transfer(c, a);
    busy = m_byte(c, a);
    count_busy("busy_cycles", busy);
    check("cursor_col", 32'(cursor_col), 32'(mcol));
    check("cursor_row", 32'(cursor_row), 32'(mrow));
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(32, 255));
  endfunction

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    in_attr  = 8'h00;
    cx       = '0;
    cy       = '0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("rst_character", 32'(character), 0);
    check("rst_attribute", 32'(attribute), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_cursor_col", 32'(cursor_col), 0);
    check("rst_cursor_row", 32'(cursor_row), 0);

    // Power-up clear
    reset_n = 1'b1;
    m_clear();
    count_busy("init_clear_cycles", CELLS);
    check("init_cursor_col", 32'(cursor_col), 0);
    check("init_cursor_row", 32'(cursor_row), 0);
    sweep("init_screen");

    // Single printable byte; every pixel of cell 0
    send(8'h41, 8'h1F);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) begin qx.push_back(x); qy.push_back(y); end
    run_reads("cell0_pixels");

    // Full line from col 0 wraps the cursor to the next row
    send(8'h0D, 8'h00);
    for (int i = 0; i < COLS; i++) send(rnd_print(), 8'($urandom));
    check("wrap_cursor_col", 32'(cursor_col), 0);
    check("wrap_cursor_row", 32'(cursor_row), 1);
    send(8'h42, 8'h2E);
    qx.push_back(0); qy.push_back(16);
    qx.push_back(7); qy.push_back(31);
    run_reads("row1_first_cell");
    sweep("after_line");

    // Fill distinct text on rows down to 24, then LF scrolls
    while (mrow < ROWS - 1) begin
      for (int i = 0; i < 5; i++) send(rnd_print(), 8'($urandom));
      send(8'h0A, 8'h00);
    end
    for (int i = 0; i < 7; i++) send(rnd_print(), 8'($urandom));
    send(8'h0A, 8'h00);
    for (int i = 0; i < 16; i++) begin qx.push_back(i * 40); qy.push_back(384 + i); end
    run_reads("scrolled_bottom_blank");
    sweep("after_scroll");

    // Mixed random stream of controls and printables, including wrap-scrolls
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 11))
        0: send(8'h0D, 8'($urandom));
        1: send(8'h0A, 8'($urandom));
        2: send(8'h08, 8'($urandom));
        3: send(8'($urandom_range(0, 1) ? 8'h07 : 8'h1B), 8'($urandom));
        4: send(8'h00, 8'($urandom));
        default: send(rnd_print(), 8'($urandom));
      endcase
    end
    sweep("after_random");

    // Backspace at col 0 does nothing; backspace mid-line does not erase
    send(8'h0D, 8'h00);
    send(8'h08, 8'h00);
    send(8'h58, 8'h4C);
    send(8'h08, 8'h00);
    qx.push_back(0); qy.push_back(mrow * 16);
    run_reads("bs_no_erase");

    // Form feed mid-line
    send(8'h31, 8'h07);
    send(8'h32, 8'h07);
    send(8'h0C, 8'h00);
    sweep("after_ff");

    // Out-of-range pixels force zero
    qx.push_back(640);  qy.push_back(0);
    qx.push_back(0);    qy.push_back(400);
    qx.push_back(1023); qy.push_back(1023);
    qx.push_back(639);  qy.push_back(399);
    for (int i = 0; i < 6; i++) begin
      qx.push_back(int'($urandom_range(640, 1023))); qy.push_back(int'($urandom_range(0, 1023)));
      qx.push_back(int'($urandom_range(0, 1023)));   qy.push_back(int'($urandom_range(400, 1023)));
    end
    run_reads("out_of_range");

    // Reset pulsed mid-scroll restarts the full clear
    for (int i = 0; i < 3; i++) send(rnd_print(), 8'($urandom));
    while (mrow < ROWS - 1) send(8'h0A, 8'h00);
    send(8'h44, 8'h1E);
    transfer(8'h0A, 8'h00);
    repeat (30) @(posedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b0;
    #1;
    check("midscroll_rst_ready", 32'(in_ready), 0);
    check("midscroll_rst_character", 32'(character), 0);
    check("midscroll_rst_cursor_row", 32'(cursor_row), 0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    m_clear();
    count_busy("midscroll_clear_cycles", CELLS);
    check("midscroll_cursor_col", 32'(cursor_col), 0);
    check("midscroll_cursor_row", 32'(cursor_row), 0);
    sweep("after_midscroll_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
